mcu_multi_ctrl: RTL

Parametrised multi-channel successor to the single-channel cipher MCU. Arbitrates NUM_CH receive FIFOs round-robin into one shared cipher datapath and sequences key load/generation with a programmable wait. Holds a per-channel encrypt/decrypt mode and tracks the channel of every in-flight block, so each data_done enqueues into the correct transmit FIFO. Sits between the per-channel Rx/Tx FIFOs and the key-generation/cipher core.

---
 rtl/mcu_pkg.sv | 28 ++
 rtl/mcu_tag_fifo.sv | 62 ++++++
 rtl/mcu_multi_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the multi-channel cipher MCU.
//   mcu_state_t    : controller state encoding (4-bit)
//   STATUS_*       : bit positions inside each channel's 4-bit status nibble
//   STATUS_RST     : per-channel status nibble after reset
//   idx_width()    : width of an index into n items, never less than 1
package mcu_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      KEY_LOAD = 4'd1,
      KEY_WAIT = 4'd2,
      KEY_DONE = 4'd3,
      DATA_REQ = 4'd4,
      DATA_DEQ = 4'd5
   } mcu_state_t;

   localparam int unsigned STATUS_FULL_RX = 0;
   localparam int unsigned STATUS_TX_NE   = 1;
   localparam int unsigned STATUS_ENC     = 2;
   localparam int unsigned STATUS_KEYV    = 3;

   localparam logic [3:0] STATUS_RST = 4'b0100;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mcu_tag_fifo.sv
// Channel-tag FIFO: remembers which channel each in-flight cipher block came from.
// Ports:
//   clk, reset (sync, active-high)
//   push, push_data : enqueue a channel ID
//   pop             : dequeue the head (ignored when empty)
//   head            : oldest channel ID (valid only when !empty)
//   full, empty     : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module mcu_tag_fifo
   import mcu_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = idx_width(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q, rd_q, wr_next, rd_next;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign head    = mem[rd_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);

   assign wr_next = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
   assign rd_next = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_next;
         if (do_pop)  rd_q <= rd_next;
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Payload storage needs no reset; head is only consumed when !empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= push_data;
   end

endmodule

// File: rtl/mcu_multi_ctrl.sv
// Multi-channel cipher MCU controller.
// Arbitrates NUM_CH Rx FIFOs round-robin into one cipher core, sequences key
// load/generation, keeps a per-channel encrypt/decrypt mode and routes each
// finished block to the Tx FIFO of the channel it came from.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   key_in, key_ch        : key-load request and the Rx channel holding the key
//   generation_done       : key schedule complete
//   enc_pulse, dec_pulse  : per-channel mode set/clear (enc wins)
//   empty_rx, full_rx     : Rx FIFO flags;  empty_tx : Tx FIFO empty flags
//   accepted, data_done   : cipher core handshake
//   read_fifo, sel_ch     : block presented to core and its channel
//   rcv_deq, trans_enq    : one-hot Rx dequeue / Tx enqueue
//   mcu_key_in            : key-load strobe
//   is_encrypt, key_valid : per-channel mode, sticky key-ready flag
//   err                   : sticky watchdog error
//   status_bits           : registered {key_valid, enc, tx_not_empty, rx_full} per channel
// Build option: define MCU_TIMEOUT_EN to enable the DATA_REQ watchdog.
module mcu_multi_ctrl
   import mcu_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned KEYGEN_WAIT = 3,
   parameter int unsigned TAG_DEPTH   = 4,
   parameter int unsigned TIMEOUT_CYC = 16,
   localparam int unsigned CH_W       = idx_width(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_in,
   input  logic [CH_W-1:0]       key_ch,
   input  logic                  generation_done,
   input  logic [NUM_CH-1:0]     enc_pulse,
   input  logic [NUM_CH-1:0]     dec_pulse,
   input  logic [NUM_CH-1:0]     empty_rx,
   input  logic [NUM_CH-1:0]     full_rx,
   input  logic [NUM_CH-1:0]     empty_tx,
   input  logic                  accepted,
   input  logic                  data_done,
   output logic                  read_fifo,
   output logic [CH_W-1:0]       sel_ch,
   output logic [NUM_CH-1:0]     rcv_deq,
   output logic [NUM_CH-1:0]     trans_enq,
   output logic                  mcu_key_in,
   output logic [NUM_CH-1:0]     is_encrypt,
   output logic                  key_valid,
   output logic                  err,
   output logic [4*NUM_CH-1:0]   status_bits
);

   localparam int unsigned WAIT_W = idx_width(KEYGEN_WAIT);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("NUM_CH must be at least 1");
   end
   if (KEYGEN_WAIT < 1) begin : g_bad_keygen_wait
      $error("KEYGEN_WAIT must be at least 1");
   end
   if ((TAG_DEPTH == 0) || ((TAG_DEPTH & (TAG_DEPTH - 1)) != 0)) begin : g_bad_tag_depth
      $error("TAG_DEPTH must be a power of 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   mcu_state_t          state_q, state_d;
   logic [CH_W-1:0]     sel_ch_q, sel_ch_d, key_ch_q, key_ch_d, rr_ptr_q, rr_ptr_d, sel_next;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                key_valid_q, key_valid_d;
   logic [NUM_CH-1:0]   is_enc_q, is_enc_d;
   logic [4*NUM_CH-1:0] status_q, status_d;
   logic                tag_push, tag_pop, tag_full, tag_empty;
   logic [CH_W-1:0]     tag_head;
   logic [NUM_CH-1:0]   eligible;
   logic                pick_found;
   logic [CH_W-1:0]     pick_ch;
   logic                timeout;

`ifdef MCU_TIMEOUT_EN
   localparam int unsigned TO_W = idx_width(TIMEOUT_CYC);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            err_q;

   assign timeout  = (state_q == DATA_REQ) && !accepted && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
   // Counter restarts from zero on every entry into DATA_REQ.
   assign to_cnt_d = (state_q == DATA_REQ) ? to_cnt_q + 1'b1 : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         if (timeout) err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   assign sel_next = (sel_ch_q == CH_W'(NUM_CH - 1)) ? '0 : sel_ch_q + 1'b1;
   assign eligible = ~empty_rx & {NUM_CH{key_valid_q && !tag_full}};

   // Round-robin: first eligible channel at or after rr_ptr, cyclically.
   always_comb begin
      int unsigned pos;
      pick_found = 1'b0;
      pick_ch    = '0;
      pos        = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         pos = (32'(rr_ptr_q) + 32'(k)) % NUM_CH;
         if (!pick_found && eligible[pos[CH_W-1:0]]) begin
            pick_found = 1'b1;
            pick_ch    = pos[CH_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_ch_d    = sel_ch_q;
      key_ch_d    = key_ch_q;
      rr_ptr_d    = rr_ptr_q;
      wait_d      = wait_q;
      key_valid_d = key_valid_q;
      unique case (state_q)
         IDLE: begin
            if (key_in) begin
               state_d  = KEY_LOAD;
               key_ch_d = key_ch;
            end else if (pick_found) begin
               state_d  = DATA_REQ;
               sel_ch_d = pick_ch;
            end
         end
         KEY_LOAD: begin
            wait_d  = WAIT_W'(KEYGEN_WAIT - 1);
            state_d = KEY_WAIT;
         end
         KEY_WAIT: begin
            if (wait_q == '0) begin
               state_d = KEY_DONE;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         KEY_DONE: begin
            if (generation_done) begin
               key_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         DATA_REQ: begin
            if (accepted) begin
               state_d = DATA_DEQ;
            end else if (timeout) begin
               // Skip the stalled channel so others are not starved.
               state_d  = IDLE;
               rr_ptr_d = sel_next;
            end
         end
         DATA_DEQ: begin
            rr_ptr_d = sel_next;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign is_enc_d = (is_enc_q & ~dec_pulse) | enc_pulse;

   always_comb begin
      status_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         status_d[4*i + STATUS_KEYV]    = key_valid_q;
         status_d[4*i + STATUS_ENC]     = is_enc_q[i];
         status_d[4*i + STATUS_TX_NE]   = !empty_tx[i];
         status_d[4*i + STATUS_FULL_RX] = full_rx[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sel_ch_q    <= '0;
         key_ch_q    <= '0;
         rr_ptr_q    <= '0;
         wait_q      <= '0;
         key_valid_q <= 1'b0;
         is_enc_q    <= '1;
         status_q    <= {NUM_CH{STATUS_RST}};
      end else begin
         state_q     <= state_d;
         sel_ch_q    <= sel_ch_d;
         key_ch_q    <= key_ch_d;
         rr_ptr_q    <= rr_ptr_d;
         wait_q      <= wait_d;
         key_valid_q <= key_valid_d;
         is_enc_q    <= is_enc_d;
         status_q    <= status_d;
      end
   end

   assign tag_push = (state_q == DATA_DEQ);
   assign tag_pop  = data_done && !tag_empty;

   mcu_tag_fifo #(
      .WIDTH (CH_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tag_push),
      .push_data (sel_ch_q),
      .pop       (tag_pop),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   always_comb begin
      rcv_deq = '0;
      if (state_q == KEY_LOAD) begin
         rcv_deq[key_ch_q] = 1'b1;
      end else if (state_q == DATA_DEQ) begin
         rcv_deq[sel_ch_q] = 1'b1;
      end
   end

   // Enqueue is combinational so the Tx write lines up with data_done.
   always_comb begin
      trans_enq = '0;
      if (tag_pop) trans_enq[tag_head] = 1'b1;
   end

   assign read_fifo   = (state_q == DATA_REQ);
   assign mcu_key_in  = (state_q == KEY_LOAD);
   assign sel_ch      = sel_ch_q;
   assign is_encrypt  = is_enc_q;
   assign key_valid   = key_valid_q;
   assign status_bits = status_q;

endmodule
